// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if: producer-side and consumer-side handshake channels of
// the immediate decode stage, bundled so the stage takes one bus port.
// slave  : the decode stage itself (accepts in_*, drives out_*).
// master : whoever drives the stage (producer + consumer, e.g. a bench).
interface imm_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decodes the RISC-V immediate of each incoming instruction
// and buffers the result in a 2-entry skid buffer (latency 1, FIFO order).
// Optional feature: define IMM_ILLEGAL_CHECK_EN to flag unrecognised opcodes
// (and inst[1:0] != 2'b11) as illegal; otherwise they decode as I-type.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  imm_decode_stage_if.slave bus
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_Z = 3'd5;
  localparam logic [2:0] FMT_R = 3'd6;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{imm: '0, fmt: FMT_R, tag: '0, illegal: 1'b0};

  // Pure combinational decode of one instruction word into a buffer entry.
  function automatic entry_t decode(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    entry_t          d;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic            known;
    logic            zext;
    d     = RESET_ENTRY;
    d.tag = tag;
    imm32 = '0;
    known = 1'b1;
    zext  = 1'b0;
    case (inst[6:2])
      5'b01101, 5'b00101: begin // LUI, AUIPC
        d.fmt = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      5'b11011: begin // JAL
        d.fmt = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      5'b11001, 5'b00000, 5'b00100: begin // JALR, LOAD, OP-IMM
        d.fmt = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      5'b11000: begin // BRANCH
        d.fmt = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      5'b01000: begin // STORE
        d.fmt = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      5'b11100: begin // SYSTEM: CSR zimm
        d.fmt = FMT_Z;
        zext  = 1'b1;
      end
      5'b01100: d.fmt = FMT_R; // OP
      5'b00110: begin // OP-IMM-32 exists only on RV64
        if (XLEN == 64) begin
          d.fmt = FMT_I;
          imm32 = {{20{inst[31]}}, inst[31:20]};
        end else begin
          known = 1'b0;
        end
      end
      5'b01110: begin // OP-32 exists only on RV64
        if (XLEN == 64) d.fmt = FMT_R;
        else            known = 1'b0;
      end
      default: known = 1'b0;
    endcase

    // Unrecognised opcodes fall back to the I layout.
    if (!known) begin
      d.fmt = FMT_I;
      imm32 = {{20{inst[31]}}, inst[31:20]};
    end

    // Sign-extend the 32-bit form from inst[31]; zimm is zero-extended.
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
    if (zext) begin
      imm      = '0;
      imm[4:0] = inst[19:15];
    end
    d.imm = imm;

`ifdef IMM_ILLEGAL_CHECK_EN
    if (!known || (inst[1:0] != 2'b11)) begin
      d.fmt     = FMT_R;
      d.imm     = '0;
      d.illegal = 1'b1;
    end
`else
    d.illegal = 1'b0;
`endif
    return d;
  endfunction

  state_e state_q, state_d;
  entry_t head_q, tail_q;
  entry_t dec_w;
  logic   in_ready_w, push, pop;
  logic   load_head_in, load_head_tail, load_tail;

`ifndef IMM_ILLEGAL_CHECK_EN
  // Low opcode bits are deliberately ignored when the check is disabled.
  logic unused_lsbs;
  assign unused_lsbs = ^bus.in_inst[1:0];
`endif

  assign dec_w      = decode(bus.in_inst, bus.in_tag);
  // Ready depends only on registered state and flush, never on out_ready.
  assign in_ready_w = (state_q != S_TWO) && !flush;
  assign push       = bus.in_valid && in_ready_w;
  assign pop        = bus.out_valid && bus.out_ready;

  // Buffer occupancy register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy and which storage slots to load this cycle.
  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d      = S_ONE;
            load_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (push && !pop) begin
            state_d   = S_TWO;
            load_tail = 1'b1;
          end else if (!push && pop) begin
            state_d = S_EMPTY;
          end else if (push && pop) begin
            load_head_in = 1'b1;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d        = S_ONE;
            load_head_tail = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Entry storage: head drives the outputs, tail is the skid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= RESET_ENTRY;
      tail_q <= RESET_ENTRY;
    end else begin
      if (load_head_in)        head_q <= dec_w;
      else if (load_head_tail) head_q <= tail_q;
      if (load_tail)           tail_q <= dec_w;
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.out_valid   = (state_q != S_EMPTY);
  assign bus.out_imm     = head_q.imm;
  assign bus.out_fmt     = head_q.fmt;
  assign bus.out_tag     = head_q.tag;
`ifdef IMM_ILLEGAL_CHECK_EN
  assign bus.out_illegal = head_q.illegal;
`else
  assign bus.out_illegal = 1'b0;
`endif

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32; datapath width, legal values 32 or 64.
REQ-002 SHALL have parameter TAG_W, default 32; width of the sideband tag (PC) carried with each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all buffered entries.
REQ-006 SHALL have port in_valid  input  1  producer holds a valid instruction.
REQ-007 SHALL have port in_ready  output  1  stage can accept; a transfer occurs when in_valid and in_ready are both high.
REQ-008 SHALL have port in_inst  input  32  raw instruction word.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband tag.
REQ-010 SHALL have port out_valid  output  1  output entry valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-012 SHALL have port out_imm  output  XLEN  decoded immediate.
REQ-013 SHALL have port out_fmt  output  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR zimm), 6=R (no immediate).
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the output entry.
REQ-015 SHALL have port out_illegal  output  1  opcode not recognised.

Function
REQ-016 SHALL decode on inst[6:2]: 01101 LUI, 00101 AUIPC -> U; 11011 -> J; 11001 JALR, 00000 LOAD, 00100 OP-IMM -> I; 11000 -> B; 01000 -> S; 11100 -> Z; 01100 OP -> R.
REQ-017 SHALL, when XLEN=64, also decode 00110 (OP-IMM-32) as I and 01110 (OP-32) as R; for XLEN=32 these opcodes are unrecognised.
REQ-018 SHALL form immediates per the RISC-V base formats: I=inst[31:20]; S={inst[31:25],inst[11:7]}; B={inst[31],inst[7],inst[30:25],inst[11:8],0}; U={inst[31:12],12'b0}; J={inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-019 SHALL sign-extend I, S, B, U and J immediates from bit 31 of the instruction to XLEN.
REQ-020 SHALL zero-extend Z to inst[19:15] and drive R immediates as 0.
REQ-021 SHALL register the decoded result: an instruction accepted at edge N appears on the output at N+1 at the earliest (latency 1).
REQ-022 SHALL implement a 2-entry skid buffer with states EMPTY, ONE, TWO; in_ready = (state != TWO) and not flush, driven from registered state plus flush only.
REQ-023 SHALL transition: EMPTY+in -> ONE; ONE+in without out -> TWO; ONE+out without in -> EMPTY; ONE+in+out -> ONE; TWO+out -> ONE; otherwise hold.
REQ-024 SHALL present entries in FIFO order and hold out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL keep out_valid = (state != EMPTY).
REQ-026 SHALL, on flush, go to EMPTY at the next edge; flush takes priority over simultaneous input and output transfers, and no input is accepted in a flush cycle.

Reset
REQ-027 SHALL, while rst is high at a clock edge, go to EMPTY and drive out_valid=0, out_imm=0, out_fmt=6, out_tag=0, out_illegal=0.
REQ-028 SHALL discard any buffered entries when rst is asserted mid-operation; rst takes priority over flush and all transfers; in_ready=1 on the first cycle after reset is released.

Configuration
REQ-029 SHALL use macro IMM_ILLEGAL_CHECK_EN to select illegal-instruction detection.
REQ-030 SHALL, with IMM_ILLEGAL_CHECK_EN defined, flag out_illegal=1, out_fmt=6 and out_imm=0 for an unrecognised opcode or inst[1:0]!=2'b11.
REQ-031 SHALL, without IMM_ILLEGAL_CHECK_EN, tie out_illegal to 0 and decode unrecognised opcodes as I, ignoring inst[1:0].

Verification
REQ-032 SHALL cover: XLEN=32, in 0xFFF00093 (addi, imm -1) with out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_fmt=0, out_valid=1.
REQ-033 SHALL cover: XLEN=64, in 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000, out_fmt=3; in 0x0000009B (addiw) -> out_fmt=0, out_illegal=0.
REQ-034 SHALL cover: out_ready=0, three back-to-back jal 0x0080006F/0x0100006F/0x0180006F -> in_ready low after two; release -> out_imm 8, 16, 24 in order, with no loss or duplication.
REQ-035 SHALL cover: state TWO, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle instruction never emerges.
REQ-036 SHALL cover: with IMM_ILLEGAL_CHECK_EN, in 0x0000007F -> out_illegal=1, out_imm=0, out_fmt=6; without the macro -> out_illegal=0, out_fmt=0.
REQ-037 SHALL cover: rst asserted for one edge while in state TWO -> out_valid=0, out_fmt=6, and the next accepted csrrwi 0x3401D073 -> out_imm=3, out_fmt=5.
